dtree_seq_walker: RTL and testbench

Sequential decision-tree classifier engine. One shared comparator walks a programmable node table, one node per clock, instead of instantiating the whole tree as combinational logic.
Features arrive serially over a valid/ready stream. The class label leaves over a valid/ready result port.
The node table is written through a config port. This block is the scheduler and sequencer for the shared compare resource in the pendigits tree flow.

---
 rtl/dtree_seq_walker.sv | 140 ++++++++++++++
 tb/tb_dtree_seq_walker.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/dtree_seq_walker.sv
// Sequential decision-tree classifier: one shared comparator walks a node table, one node per clock.
// Latency: last feature beat at edge E -> out_valid from edge E+d+1 for a leaf at depth d.
// Backpressure: s_ready low outside LOAD; the result is held in DONE until out_ready; table writes are stalled in WALK.
module dtree_seq_walker #(
  parameter int N_FEAT    = 16,
  parameter int FEAT_W    = 8,
  parameter int NODE_AW   = 5,
  parameter int CLS_W     = 4,
  parameter int MAX_DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [FEAT_W-1:0]  s_data,
  input  logic               cfg_we,
  output logic               cfg_ready,
  input  logic [NODE_AW-1:0] cfg_addr,
  input  logic [25:0]        cfg_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CLS_W-1:0]   out_class,
  output logic               out_err
);

  localparam int CNT_W   = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
  localparam int DEPTH_W = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;
  localparam int CMP_W   = FEAT_W + 8;
  localparam int DEPTH_N = 1 << NODE_AW;
  // Reset-default node: a leaf with class 0, so an unprogrammed table still terminates.
  localparam logic [25:0] LEAF_CLS0 = 26'h200_0000;

  typedef enum logic [1:0] {ST_LOAD, ST_WALK, ST_DONE} state_t;

  state_t               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [NODE_AW-1:0]   ptr_q;
  logic [NODE_AW-1:0]   ptr_d;
  logic [DEPTH_W-1:0]   depth_q;
  logic [FEAT_W-1:0]    feat_q [N_FEAT];
  logic [25:0]          tbl_q  [DEPTH_N];
  logic                 out_valid_q;
  logic [CLS_W-1:0]     out_class_q;
  logic                 out_err_q;

  // Node word fields of the node currently addressed by the walk pointer.
  logic [25:0]          node_w;
  logic                 node_leaf;
  logic [3:0]           node_fidx;
  logic [2:0]           node_shamt;
  logic [7:0]           node_thr;
  logic [FEAT_W-1:0]    feat_sel;
  logic [FEAT_W-1:0]    feat_shr;
  logic                 go_left;

  assign node_w     = tbl_q[ptr_q];
  assign node_leaf  = node_w[25];
  assign node_fidx  = node_w[24:21];
  assign node_shamt = node_w[20:18];
  assign node_thr   = node_w[17:10];

  assign s_ready    = (state_q == ST_LOAD);
  assign cfg_ready  = (state_q != ST_WALK);
  assign out_valid  = out_valid_q;
  assign out_class  = out_class_q;
  assign out_err    = out_err_q;

  // Shared comparator: out-of-range feature indices fall back to feature 0.
  always_comb begin
    feat_sel = feat_q[0];
    if (int'(node_fidx) < N_FEAT) feat_sel = feat_q[CNT_W'(node_fidx)];
    feat_shr = feat_sel >> node_shamt;
    go_left  = (CMP_W'(feat_shr) <= CMP_W'(node_thr));
    ptr_d    = go_left ? NODE_AW'(node_w[9:5]) : NODE_AW'(node_w[4:0]);
  end

  // Node table: written only outside WALK so a walk always sees a stable table.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH_N; i++) tbl_q[i] <= LEAF_CLS0;
    end else if (cfg_we && cfg_ready) begin
      tbl_q[cfg_addr] <= cfg_data;
    end
  end

  // Sequencer FSM: load features, walk one node per cycle, hold result until consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_LOAD;
      cnt_q       <= '0;
      ptr_q       <= '0;
      depth_q     <= '0;
      out_valid_q <= 1'b0;
      out_class_q <= '0;
      out_err_q   <= 1'b0;
      for (int i = 0; i < N_FEAT; i++) feat_q[i] <= '0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (s_valid) begin
            feat_q[cnt_q] <= s_data;
            if (cnt_q == CNT_W'(N_FEAT - 1)) begin
              cnt_q   <= '0;
              ptr_q   <= '0;
              depth_q <= '0;
              state_q <= ST_WALK;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        ST_WALK: begin
          if (node_leaf) begin
            out_class_q <= CLS_W'(node_w[13:10]);
            out_err_q   <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end else if (depth_q == DEPTH_W'(MAX_DEPTH - 1)) begin
            // Depth limit reached on an internal node: the table likely has a cycle.
            out_class_q <= '0;
            out_err_q   <= 1'b1;
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end else begin
            ptr_q   <= ptr_d;
            depth_q <= depth_q + DEPTH_W'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_LOAD;
          end
        end
        default: state_q <= ST_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_dtree_seq_walker.sv
// Directed bench for dtree_seq_walker: hand-computed classes, latencies and handshake behaviour.
module tb_dtree_seq_walker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  s_data = '0;
  logic        cfg_we = 1'b0;
  logic        cfg_ready;
  logic [4:0]  cfg_addr = '0;
  logic [25:0] cfg_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  out_class;
  logic        out_err;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] fv [16];

  dtree_seq_walker dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .cfg_we(cfg_we), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class), .out_err(out_err)
  );

  always #5 clk = ~clk;

  function automatic logic [25:0] mk_node(input logic [3:0] f, input logic [2:0] sh,
                                          input logic [7:0] thr, input logic [4:0] l, input logic [4:0] r);
    return {1'b0, f, sh, thr, l, r};
  endfunction

  function automatic logic [25:0] mk_leaf(input logic [3:0] c);
    return {1'b1, 11'd0, c, 10'd0};
  endfunction

  task automatic cfg_write(input logic [4:0] a, input logic [25:0] d);
    int t;
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d; t = 0;
    while (!cfg_ready && t < 50) begin @(negedge clk); t++; end
    if (!cfg_ready) begin
      n_vec++; n_err++;
      $display("FAIL cfg_write_timeout: cfg_ready=%b, required 1", cfg_ready);
    end
    @(posedge clk); #1 cfg_we = 1'b0;
  endtask

  // Presents beats first..last back to back; returns at the negedge after the last accepted beat.
  task automatic load_beats(input int first, input int last);
    int t;
    for (int k = first; k <= last; k++) begin
      @(negedge clk);
      s_valid = 1'b1; s_data = fv[k]; t = 0;
      while (!s_ready && t < 50) begin @(negedge clk); t++; end
      if (!s_ready) begin
        n_vec++; n_err++;
        $display("FAIL beat_timeout: beat %0d s_ready=%b, required 1", k, s_ready);
      end
      @(posedge clk);
    end
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  // Counts edges after the last beat edge until out_valid is seen.
  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); lat++;
      @(negedge clk);
    end
  endtask

  task automatic ack();
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
  endtask

  task automatic run_sample(output int lat, output logic [3:0] cls, output logic err);
    load_beats(0, 15);
    wait_result(lat);
    cls = out_class; err = out_err;
    ack();
  endtask

  task automatic program_tree(input logic [7:0] thr2);
    cfg_write(5'd0, mk_node(4'd15, 3'd6, 8'd1, 5'd1, 5'd2));
    cfg_write(5'd1, mk_leaf(4'd6));
    cfg_write(5'd2, mk_node(4'd15, 3'd5, thr2, 5'd3, 5'd4));
    cfg_write(5'd3, mk_leaf(4'd3));
    cfg_write(5'd4, mk_leaf(4'd9));
  endtask

  task automatic test_reset();
    int lat; logic [3:0] cls; logic err;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++; if (s_ready !== 1'b1)   begin n_err++; $display("FAIL rst_s_ready: got %b, required 1", s_ready); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b, required 0", out_valid); end
    n_vec++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL rst_cfg_ready: got %b, required 1", cfg_ready); end
    n_vec++; if (out_class !== 4'd0) begin n_err++; $display("FAIL rst_out_class: got %0d, required 0", out_class); end
    n_vec++; if (out_err !== 1'b0)   begin n_err++; $display("FAIL rst_out_err: got %b, required 0", out_err); end
    rst_n = 1'b1;
    // Unprogrammed table: root is a class-0 leaf, result one edge after the last beat.
    run_sample(lat, cls, err);
    n_vec++; if (lat != 1)    begin n_err++; $display("FAIL dflt_latency: got %0d, required 1", lat); end
    n_vec++; if (cls !== 4'd0) begin n_err++; $display("FAIL dflt_class: got %0d, required 0", cls); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL dflt_err: got %b, required 0", err); end
  endtask

  task automatic test_tree();
    int lat; logic [3:0] cls; logic err;
    logic [7:0] xs [5];
    logic [3:0] ec [5];
    int el [5];
    // Entry 2 sits exactly on node2's threshold (0xFF>>5 = 7 <= 7), so it goes left.
    // Entries 3,4 run after node2's threshold drops to 6, reaching the right leaf.
    xs = '{8'h3F, 8'hC0, 8'hFF, 8'hFF, 8'hC0};
    ec = '{4'd6, 4'd3, 4'd3, 4'd9, 4'd3};
    el = '{2, 3, 3, 3, 3};
    program_tree(8'd7);
    for (int i = 0; i < 5; i++) begin
      if (i == 3) cfg_write(5'd2, mk_node(4'd15, 3'd5, 8'd6, 5'd3, 5'd4));
      fv[15] = xs[i];
      run_sample(lat, cls, err);
      n_vec++; if (cls !== ec[i]) begin n_err++; $display("FAIL tree_class[%0d]: got %0d, required %0d", i, cls, ec[i]); end
      n_vec++; if (lat != el[i])  begin n_err++; $display("FAIL tree_latency[%0d]: got %0d, required %0d", i, lat, el[i]); end
      n_vec++; if (err !== 1'b0)  begin n_err++; $display("FAIL tree_err[%0d]: got %b, required 0", i, err); end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    fv[15] = 8'h3F;
    load_beats(0, 15);
    wait_result(lat);
    for (int i = 0; i < 10; i++) begin
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid[%0d]: got %b, required 1", i, out_valid); end
      n_vec++; if (out_class !== 4'd6) begin n_err++; $display("FAIL bp_class[%0d]: got %0d, required 6", i, out_class); end
      n_vec++; if (s_ready !== 1'b0)   begin n_err++; $display("FAIL bp_s_ready[%0d]: got %b, required 0", i, s_ready); end
      @(negedge clk);
    end
    // Handshake edge with a beat already presented: the beat must wait one more edge.
    out_ready = 1'b1; s_valid = 1'b1; s_data = fv[0];
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_valid_drop: got %b, required 0", out_valid); end
    n_vec++; if (s_ready !== 1'b1)   begin n_err++; $display("FAIL bp_s_ready_load: got %b, required 1", s_ready); end
    @(posedge clk);
    // fv[14]=0xE1 would steer to class 9 if the stream had slipped by one beat.
    load_beats(1, 15);
    wait_result(lat);
    n_vec++; if (out_class !== 4'd6) begin n_err++; $display("FAIL bp_next_class: got %0d, required 6", out_class); end
    n_vec++; if (lat != 2)           begin n_err++; $display("FAIL bp_next_latency: got %0d, required 2", lat); end
    ack();
  endtask

  task automatic test_cfg_gating();
    int lat; logic [3:0] cls; logic err;
    fv[15] = 8'h3F;
    load_beats(0, 15);
    cfg_we = 1'b1; cfg_addr = 5'd1; cfg_data = mk_leaf(4'd12);
    #1;
    n_vec++; if (cfg_ready !== 1'b0) begin n_err++; $display("FAIL gate_cfg_ready_walk: got %b, required 0", cfg_ready); end
    wait_result(lat);
    n_vec++; if (out_class !== 4'd6) begin n_err++; $display("FAIL gate_cur_class: got %0d, required 6", out_class); end
    n_vec++; if (lat != 2)           begin n_err++; $display("FAIL gate_latency: got %0d, required 2", lat); end
    n_vec++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL gate_cfg_ready_done: got %b, required 1", cfg_ready); end
    @(posedge clk); #1 cfg_we = 1'b0;
    @(negedge clk);
    n_vec++; if (out_class !== 4'd6) begin n_err++; $display("FAIL gate_held_class: got %0d, required 6", out_class); end
    ack();
    run_sample(lat, cls, err);
    n_vec++; if (cls !== 4'd12) begin n_err++; $display("FAIL gate_new_class: got %0d, required 12", cls); end
  endtask

  task automatic test_loop();
    int lat; logic [3:0] cls; logic err;
    cfg_write(5'd0, mk_node(4'd0, 3'd0, 8'd0, 5'd0, 5'd0));
    run_sample(lat, cls, err);
    n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL loop_err: got %b, required 1", err); end
    n_vec++; if (cls !== 4'd0) begin n_err++; $display("FAIL loop_class: got %0d, required 0", cls); end
    n_vec++; if (lat != 8)     begin n_err++; $display("FAIL loop_latency: got %0d, required 8", lat); end
  endtask

  task automatic test_mid_reset();
    int lat; logic [3:0] cls; logic err;
    fv[15] = 8'hC0;
    load_beats(0, 6);
    rst_n = 1'b0; #1;
    n_vec++; if (s_ready !== 1'b1)   begin n_err++; $display("FAIL mr1_s_ready: got %b, required 1", s_ready); end
    n_vec++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL mr1_cfg_ready: got %b, required 1", cfg_ready); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mr1_out_valid: got %b, required 0", out_valid); end
    @(negedge clk); rst_n = 1'b1;
    program_tree(8'd7);
    load_beats(0, 15);
    n_vec++; if (cfg_ready !== 1'b0) begin n_err++; $display("FAIL mr2_in_walk: got %b, required 0", cfg_ready); end
    rst_n = 1'b0; #1;
    n_vec++; if (s_ready !== 1'b1)   begin n_err++; $display("FAIL mr2_s_ready: got %b, required 1", s_ready); end
    n_vec++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL mr2_cfg_ready: got %b, required 1", cfg_ready); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mr2_out_valid: got %b, required 0", out_valid); end
    n_vec++; if (out_err !== 1'b0)   begin n_err++; $display("FAIL mr2_out_err: got %b, required 0", out_err); end
    @(negedge clk); rst_n = 1'b1;
    program_tree(8'd7);
    run_sample(lat, cls, err);
    n_vec++; if (cls !== 4'd3) begin n_err++; $display("FAIL mr_class: got %0d, required 3", cls); end
    n_vec++; if (lat != 3)     begin n_err++; $display("FAIL mr_latency: got %0d, required 3", lat); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL mr_err: got %b, required 0", err); end
  endtask

  initial begin
    for (int k = 0; k < 16; k++) fv[k] = 8'(k * 16 + 1);
    test_reset();
    test_tree();
    test_backpressure();
    test_cfg_gating();
    test_loop();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
